// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - state_e   : converter FSM states (IDLE, SHIFT, DONE)
//   - SEG_BLANK : active-low segment pattern with every segment off
//   - SEG_TABLE : 16-entry digit -> gfedcba active-low segment table
//   - digits_fit: elaboration helper, true when 10^d > 2^n
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index is the digit value; 10..15 cannot come out of the converter and
  // are shown blank rather than as hex letters.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    SEG_BLANK, SEG_BLANK
  };

  function automatic bit digits_fit(input int n, input int d);
    logic [127:0] p10;
    p10 = 128'd1;
    for (int i = 0; i < d; i++) p10 = p10 * 128'd10;
    return p10 > (128'd1 << n);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if
// Handshake/data bundle between a requester (master) and bin2bcd_seq (slave).
//   start : request a conversion of bin (master -> slave)
//   bin   : N-bit binary value, captured on the accepting edge
//   busy  : conversion in progress
//   done  : one-cycle completion pulse; bcd is valid from this cycle on
//   bcd   : 4*DIGITS packed decimal digits, digit 0 = units
//   state : FSM state, for observation only
//   hex   : 7*DIGITS active-low segments (only with BIN2BCD_SEG_EN)
// Handshake: start is accepted on any rising edge where the slave is in IDLE
// or DONE (i.e. busy is low); start while busy is dropped, not queued. The
// result is reported by a single-cycle done pulse, with no back-pressure.
interface bin2bcd_seq_if #(
  parameter int N      = 8,
  parameter int DIGITS = 3
);
  import bin2bcd_pkg::*;

  logic                  start;
  logic [N-1:0]          bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  state_e                state;
`ifdef BIN2BCD_SEG_EN
  logic [7*DIGITS-1:0]   hex;
`endif

  modport master (
`ifdef BIN2BCD_SEG_EN
    input  hex,
`endif
    output start, bin,
    input  busy, done, bcd, state
  );

  modport slave (
`ifdef BIN2BCD_SEG_EN
    output hex,
`endif
    input  start, bin,
    output busy, done, bcd, state
  );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational BCD digit to seven-segment decoder.
//   digit_i : 4-bit digit value
//   seg_o   : active-low segments, bit order gfedcba (values 10..15 blank)
module seg7_decode
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. A conversion accepted at edge E0 shifts on E1..EN and presents the
// result with a one-cycle done pulse in the cycle after EN.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : bin2bcd_seq_if slave (start/bin in; busy/done/bcd/state out,
//           plus hex when BIN2BCD_SEG_EN is defined)
// Optional feature macro: BIN2BCD_SEG_EN adds registered seven-segment
// outputs (one seg7_decode per digit).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!digits_fit(N, DIGITS)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS=%0d too small for N=%0d", DIGITS, N);
  end
  if (N < 2) begin : g_bad_width
    $error("bin2bcd_seq: N must be at least 2");
  end

  state_e          state_q;
  logic [N-1:0]    shift_q;
  logic [W-1:0]    scratch_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    bcd_q;

  logic [W-1:0]    adj;
  logic [W-1:0]    scratch_d;
  logic [N-1:0]    shift_d;

  // Add-3 correction on every digit >= 5, then shift {scratch, shift} left.
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
    end
    scratch_d = {adj[W-2:0], shift_q[N-1]};
    shift_d   = {shift_q[N-2:0], 1'b0};
  end

`ifdef BIN2BCD_SEG_EN
  logic [7*DIGITS-1:0] hex_d;
  logic [7*DIGITS-1:0] hex_q;

  // Decode the value about to be written to bcd so hex updates on the same edge.
  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    seg7_decode u_dec (
      .digit_i (scratch_d[4*k +: 4]),
      .seg_o   (hex_d[7*k +: 7])
    );
  end

  assign bus.hex = hex_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
`ifdef BIN2BCD_SEG_EN
      hex_q     <= {DIGITS{SEG_BLANK}};
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            shift_q   <= bus.bin;
            scratch_q <= '0;
            cnt_q     <= CW'(N - 1);
            state_q   <= SHIFT;
            busy_q    <= 1'b1;
          end else begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
          done_q <= 1'b0;
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          if (cnt_q == '0) begin
            // Last shift: publish the finished value directly, never a partial one.
            bcd_q   <= scratch_d;
`ifdef BIN2BCD_SEG_EN
            hex_q   <= hex_d;
`endif
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq (N=8, DIGITS=3). Expected results come
// from a decimal-arithmetic reference model; hex checks are compiled in when
// BIN2BCD_SEG_EN is defined.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  localparam int N      = 8;
  localparam int DIGITS = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.N(N), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.N(N), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_bcd = 12'h000;

  // Reference model: plain decimal digit extraction.
  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

`ifdef BIN2BCD_SEG_EN
  // Active-low gfedcba patterns for the decimal digits 0..9.
  logic [6:0] ref_seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  function automatic logic [20:0] to_hex(input logic [11:0] b);
    logic [20:0] r;
    for (int k = 0; k < DIGITS; k++) r[7*k +: 7] = ref_seg[b[4*k +: 4]];
    return r;
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
    check({tag, "_bcd"},   32'(bus.bcd),   32'h000);
    check({tag, "_state"}, 32'(bus.state), 32'(IDLE));
`ifdef BIN2BCD_SEG_EN
    check({tag, "_hex"},   32'(bus.hex),   32'h1FFFFF);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Drive start for one cycle; returns at the negedge after the accepting edge.
  task automatic accept(input logic [7:0] v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = v;
    exp_q.push_back(to_bcd(int'(v)));
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 8'($urandom);
  endtask

  // Follow a conversion to its done cycle. inject >= 0 pulses start with a
  // random bin during that busy cycle, which must be ignored.
  task automatic finish_conv(input int inject, input string tag);
    logic [11:0] exp;
    int n;
    exp = exp_q.pop_front();
    n = 0;
    while (bus.busy === 1'b1 && n < 4 * N) begin
      check({tag, "_hold"}, 32'(bus.bcd), 32'(last_bcd));
      check({tag, "_nodone"}, 32'(bus.done), 32'd0);
      bus.start = (n == inject);
      bus.bin   = 8'($urandom);
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_busylen"}, 32'(n), 32'(N));
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy0"}, 32'(bus.busy), 32'd0);
    check({tag, "_bcd"}, 32'(bus.bcd), 32'(exp));
`ifdef BIN2BCD_SEG_EN
    check({tag, "_hex"}, 32'(bus.hex), 32'(to_hex(exp)));
`endif
    last_bcd = exp;
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"},  32'(bus.state), 32'(IDLE));
    check({tag, "_keep"},  32'(bus.bcd), 32'(last_bcd));
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] dir_vals [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd128};
  logic [7:0] cnt_model;

  initial begin
    bus.start = 1'b0;
    bus.bin   = '0;

    // Reset held, then released with no start.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_held");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_rel");

    // Full-scale value.
    accept(8'd255);
    finish_conv(-1, "c255");
    idle_after("c255");

    // Decade boundaries.
    for (int i = 0; i < 6; i++) begin
      accept(dir_vals[i]);
      finish_conv(-1, "dir");
      idle_after("dir");
    end

    // start during SHIFT is dropped; original result delivered.
    accept(8'd200);
    finish_conv(3, "ign");
    idle_after("ign");

    // start held in DONE: straight back into SHIFT with a new value.
    accept(8'd64);
    finish_conv(-1, "b2b_a");
    bus.start = 1'b1;
    bus.bin   = 8'd37;
    exp_q.push_back(to_bcd(37));
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_noidle", 32'(bus.busy), 32'd1);
    finish_conv(-1, "b2b_b");
    idle_after("b2b_b");

    // Random values.
    repeat (20) begin
      accept(8'($urandom_range(0, 255)));
      finish_conv(int'($urandom_range(0, 9)) - 2, "rnd");
      idle_after("rnd");
    end

    // Exhaustive sweep driven from a free-running counter model.
    cnt_model = 8'd0;
    for (int c = 0; c < 256; c++) begin
      accept(cnt_model);
      finish_conv(-1, "sweep");
      cnt_model = cnt_model + 8'd1;
    end
    idle_after("sweep");

    // Reset in the 4th SHIFT cycle aborts the conversion.
    accept(8'd123);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    void'(exp_q.pop_front());
    last_bcd = 12'h000;
    @(negedge clk);
    reset = 1'b1;
    repeat (2 * N) begin
      @(negedge clk);
      check("abort_nodone", 32'(bus.done), 32'd0);
      check("abort_nobusy", 32'(bus.busy), 32'd0);
    end

    // Fresh start after abort.
    accept(8'd58);
    finish_conv(-1, "post");
    idle_after("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
